// File: rtl/vga_framebuffer_80x60.sv
`default_nettype none
// ============================================================================
// Module   : vga_framebuffer_80x60
// Brief    : 80x60-cell RRRGGGBB framebuffer with combinational display read,
//            handshaked MCU access port and a hardware clear-screen engine.
// Revision : 1.0 - initial release
// ============================================================================
module vga_framebuffer_80x60 #(
    parameter int H_CELLS    = 80,
    parameter int V_CELLS    = 60,
    parameter int CELL_SHIFT = 3
) (
    input  logic       CLK_25MHz,
    input  logic       RST,
    input  logic [9:0] PIX_ROW,
    input  logic [9:0] PIX_COL,
    output logic [2:0] RED,
    output logic [2:0] GREEN,
    output logic [1:0] BLUE,
    input  logic [6:0] MCU_X,
    input  logic [5:0] MCU_Y,
    input  logic [7:0] MCU_WD,
    input  logic       MCU_WE,
    input  logic       MCU_RE,
    output logic [7:0] MCU_RD,
    output logic       MCU_RD_VALID,
    input  logic       CLR,
    input  logic [7:0] CLR_COLOR,
    output logic       BUSY,
    output logic       READY
);

    localparam logic [9:0] c_col_cells = 10'(H_CELLS);
    localparam logic [9:0] c_row_cells = 10'(V_CELLS);
    localparam logic [6:0] c_x_last    = 7'(H_CELLS - 1);
    localparam logic [5:0] c_y_last    = 6'(V_CELLS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Cell storage; never reset so the picture survives a reset.
    logic [7:0] mem [0:8191];

    state_t     state_q, state_d;
    logic [6:0] cx_q, cx_d;
    logic [5:0] cy_q, cy_d;
    logic [7:0] color_q, color_d;
    logic [7:0] rd_q, rd_d;
    logic       rd_valid_q, rd_valid_d;

    logic [9:0]  w_col_cell;
    logic [9:0]  w_row_cell;
    logic        w_pix_in_range;
    logic [7:0]  w_pix_rgb;
    logic        w_mcu_in_range;
    logic [12:0] w_mcu_addr;
    logic        w_acc_we;
    logic        w_acc_re;
    logic        w_clr_we;
    logic        w_ram_we;
    logic [12:0] w_ram_addr;
    logic [7:0]  w_ram_wdata;

    // ------------------------------------------------------------------
    // Display path: pure combinational lookup, never stalled.
    // ------------------------------------------------------------------
    assign w_col_cell     = PIX_COL >> CELL_SHIFT;
    assign w_row_cell     = PIX_ROW >> CELL_SHIFT;
    assign w_pix_in_range = (w_col_cell < c_col_cells) && (w_row_cell < c_row_cells);
    assign w_pix_rgb      = w_pix_in_range ? mem[{w_row_cell[5:0], w_col_cell[6:0]}] : 8'h00;

    assign RED   = w_pix_rgb[7:5];
    assign GREEN = w_pix_rgb[4:2];
    assign BLUE  = w_pix_rgb[1:0];

    // ------------------------------------------------------------------
    // MCU port
    // ------------------------------------------------------------------
    assign BUSY           = (state_q == ST_CLEAR);
    assign READY          = ~BUSY;
    assign w_mcu_in_range = (MCU_X <= c_x_last) && (MCU_Y <= c_y_last);
    assign w_mcu_addr     = {MCU_Y, MCU_X};
    assign w_acc_we       = MCU_WE & READY;
    assign w_acc_re       = MCU_RE & READY;

    always_comb begin
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        if (w_acc_re) begin
            rd_valid_d = 1'b1;
            rd_d       = w_mcu_in_range ? mem[w_mcu_addr] : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        color_d  = color_q;
        w_clr_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CLR) begin
                    state_d = ST_CLEAR;
                    color_d = CLR_COLOR;
                    cx_d    = 7'd0;
                    cy_d    = 6'd0;
                end
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (cx_q == c_x_last) begin
                    cx_d = 7'd0;
                    if (cy_q == c_y_last) begin
                        cy_d    = 6'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cy_d = cy_q + 6'd1;
                    end
                end else begin
                    cx_d = cx_q + 7'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // MCU and clear writes are mutually exclusive because the MCU is only
    // accepted while idle. Reset blocks the pending clear write so an abort
    // leaves the current cell untouched.
    assign w_ram_we    = (w_clr_we & ~RST) | (w_acc_we & w_mcu_in_range);
    assign w_ram_addr  = BUSY ? {cy_q, cx_q} : w_mcu_addr;
    assign w_ram_wdata = BUSY ? color_q : MCU_WD;

    always_ff @(posedge CLK_25MHz) begin
        if (w_ram_we) begin
            mem[w_ram_addr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge CLK_25MHz) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cx_q       <= 7'd0;
            cy_q       <= 6'd0;
            color_q    <= 8'h00;
            rd_q       <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            color_q    <= color_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign MCU_RD       = rd_q;
    assign MCU_RD_VALID = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_framebuffer_80x60.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_framebuffer_80x60
// Brief    : Directed self-checking bench for vga_framebuffer_80x60.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_framebuffer_80x60;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] pix_row, pix_col;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic [6:0] mcu_x;
    logic [5:0] mcu_y;
    logic [7:0] mcu_wd;
    logic       mcu_we, mcu_re;
    logic [7:0] mcu_rd;
    logic       mcu_rd_valid;
    logic       clr;
    logic [7:0] clr_color;
    logic       busy, ready;

    int n_cmp = 0;
    int n_err = 0;

    always #20 clk = ~clk;

    vga_framebuffer_80x60 dut (
        .CLK_25MHz    (clk),
        .RST          (rst),
        .PIX_ROW      (pix_row),
        .PIX_COL      (pix_col),
        .RED          (red),
        .GREEN        (green),
        .BLUE         (blue),
        .MCU_X        (mcu_x),
        .MCU_Y        (mcu_y),
        .MCU_WD       (mcu_wd),
        .MCU_WE       (mcu_we),
        .MCU_RE       (mcu_re),
        .MCU_RD       (mcu_rd),
        .MCU_RD_VALID (mcu_rd_valid),
        .CLR          (clr),
        .CLR_COLOR    (clr_color),
        .BUSY         (busy),
        .READY        (ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mcu_write(input logic [6:0] x, input logic [5:0] y, input logic [7:0] d);
        mcu_x = x; mcu_y = y; mcu_wd = d; mcu_we = 1'b1;
        tick();
        mcu_we = 1'b0;
    endtask

    task automatic mcu_read(input logic [6:0] x, input logic [5:0] y, output logic [7:0] d);
        mcu_x = x; mcu_y = y; mcu_re = 1'b1;
        tick();
        mcu_re = 1'b0;
        d = mcu_rd;
    endtask

    function automatic logic [7:0] rgb();
        return {red, green, blue};
    endfunction

    // Starts a clear and waits for BUSY to fall; returns the BUSY cycle count.
    task automatic run_clear(input logic [7:0] color, output int cnt);
        clr = 1'b1; clr_color = color;
        tick();
        clr = 1'b0;
        cnt = 0;
        while (busy && cnt < 6000) begin
            tick();
            cnt++;
        end
    endtask

    logic [7:0] d;
    int         cnt;

    initial begin
        rst = 1'b1; pix_row = '0; pix_col = '0;
        mcu_x = '0; mcu_y = '0; mcu_wd = '0; mcu_we = 1'b0; mcu_re = 1'b0;
        clr = 1'b0; clr_color = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",  busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_rd",    mcu_rd, 0);
        chk("rst_valid", mcu_rd_valid, 0);

        // Clear to 0x03 with an ignored write attempt part-way through
        clr = 1'b1; clr_color = 8'h03;
        tick();
        clr = 1'b0;
        cnt = 0;
        while (busy && cnt < 6000) begin
            if (cnt == 1000) begin
                mcu_x = 7'd3; mcu_y = 6'd3; mcu_wd = 8'h77; mcu_we = 1'b1;
                chk("midclr_ready", ready, 0);
            end
            tick();
            cnt++;
            if (cnt == 1001) mcu_we = 1'b0;
        end
        mcu_we = 1'b0;
        chk("clr_len", cnt, 4800);
        chk("clr_ready_after", ready, 1);
        mcu_read(7'd0,  6'd0,  d); chk("clr_0_0",   d, 8'h03);
        mcu_read(7'd79, 6'd0,  d); chk("clr_79_0",  d, 8'h03);
        mcu_read(7'd0,  6'd59, d); chk("clr_0_59",  d, 8'h03);
        mcu_read(7'd79, 6'd59, d); chk("clr_79_59", d, 8'h03);
        mcu_read(7'd3,  6'd3,  d); chk("clr_ign_we", d, 8'h03);

        // Write and display
        mcu_write(7'd5, 6'd2, 8'hE3);
        for (int r = 16; r < 24; r++) begin
            for (int c = 40; c < 48; c++) begin
                pix_row = 10'(r); pix_col = 10'(c);
                #1;
                chk("disp_cell", rgb(), 8'hE3);
            end
        end
        pix_row = 10'd16; pix_col = 10'd48; #1;
        chk("disp_next_cell", rgb(), 8'h03);
        pix_row = 10'd479; pix_col = 10'd639; #1;
        chk("disp_last_px", rgb(), 8'h03);
        pix_row = 10'd10; pix_col = 10'd700; #1;
        chk("disp_col_oor", rgb(), 8'h00);
        pix_row = 10'd480; pix_col = 10'd100; #1;
        chk("disp_row_oor", rgb(), 8'h00);

        // Read latency and hold
        mcu_x = 7'd5; mcu_y = 6'd2; mcu_re = 1'b1;
        tick();
        mcu_re = 1'b0;
        chk("rd_valid_hi", mcu_rd_valid, 1);
        chk("rd_data", mcu_rd, 8'hE3);
        tick();
        chk("rd_valid_lo", mcu_rd_valid, 0);
        chk("rd_hold", mcu_rd, 8'hE3);

        // Read-before-write collision
        mcu_x = 7'd5; mcu_y = 6'd2; mcu_wd = 8'h1C; mcu_re = 1'b1; mcu_we = 1'b1;
        tick();
        mcu_re = 1'b0; mcu_we = 1'b0;
        chk("coll_old", mcu_rd, 8'hE3);
        mcu_read(7'd5, 6'd2, d); chk("coll_new", d, 8'h1C);
        pix_row = 10'd20; pix_col = 10'd44; #1;
        chk("coll_disp", rgb(), 8'h1C);

        // Out-of-range accesses
        mcu_write(7'd80, 6'd0, 8'hFF);
        mcu_read(7'd0,  6'd1, d); chk("oor_wr_0_1",  d, 8'h03);
        mcu_read(7'd79, 6'd0, d); chk("oor_wr_79_0", d, 8'h03);
        mcu_read(7'd0,  6'd0, d); chk("oor_wr_0_0",  d, 8'h03);
        mcu_read(7'd0, 6'd60, d); chk("oor_rd", d, 8'h00);

        // Clear colliding with a write and a second CLR
        mcu_x = 7'd3; mcu_y = 6'd3; mcu_wd = 8'h55; mcu_we = 1'b1;
        clr = 1'b1; clr_color = 8'h5A;
        tick();
        clr = 1'b0; mcu_we = 1'b0;
        pix_row = 10'd24; pix_col = 10'd24; #1;
        chk("coll_clr_we", rgb(), 8'h55);
        cnt = 0;
        while (busy && cnt < 6000) begin
            if (cnt == 2000) begin clr = 1'b1; clr_color = 8'h99; end
            tick();
            cnt++;
            clr = 1'b0;
        end
        chk("clr2_len", cnt, 4800);
        mcu_read(7'd3,  6'd3,  d); chk("clr2_3_3",   d, 8'h5A);
        mcu_read(7'd79, 6'd59, d); chk("clr2_79_59", d, 8'h5A);

        // Reset in the middle of a clear
        run_clear(8'hAA, cnt);
        chk("preload_len", cnt, 4800);
        clr = 1'b1; clr_color = 8'h00;
        tick();
        clr = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        mcu_read(7'd0,  6'd0,  d); chk("abort_c0",   d, 8'h00);
        mcu_read(7'd19, 6'd1,  d); chk("abort_c99",  d, 8'h00);
        mcu_read(7'd20, 6'd1,  d); chk("abort_c100", d, 8'hAA);
        mcu_read(7'd79, 6'd59, d); chk("abort_last", d, 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_framebuffer_80x60.md
Name: vga_framebuffer_80x60

Overview:
- 80x60 cell, 8-bit-per-cell (RRRGGGBB) framebuffer sitting directly upstream of the 80x60 VGA driver.
- Converts the driver's 640x480 pixel coordinates to a cell address and returns that cell's colour combinationally, before the driver's next clock edge.
- Provides an MCU-side handshaked write/read port, plus a hardware clear-screen engine that fills every cell with one colour.
- All logic is single-clock, in the pixel clock domain.

Parameters:
H_CELLS, 80, number of cell columns; valid cell X is 0..H_CELLS-1
V_CELLS, 60, number of cell rows; valid cell Y is 0..V_CELLS-1
CELL_SHIFT, 3, log2 of cell size in pixels (8x8 pixels per cell)

Ports:
CLK_25MHz  in  1  pixel clock; every port is synchronous to it
RST  in  1  synchronous, active-high reset
PIX_ROW  in  10  pixel row from VGA driver (0..524)
PIX_COL  in  10  pixel column from VGA driver (0..799)
RED  out  3  cell colour red, combinational from PIX_ROW/PIX_COL
GREEN  out  3  cell colour green, combinational
BLUE  out  2  cell colour blue, combinational
MCU_X  in  7  cell X for MCU access
MCU_Y  in  6  cell Y for MCU access
MCU_WD  in  8  write data
MCU_WE  in  1  write request
MCU_RE  in  1  read request
MCU_RD  out  8  registered read data
MCU_RD_VALID  out  1  one-cycle pulse, MCU_RD valid
CLR  in  1  start clear-screen
CLR_COLOR  in  8  fill colour, sampled when the clear starts
BUSY  out  1  clear engine active
READY  out  1  MCU port accepting requests; equals ~BUSY combinationally

Behaviour:
- Storage: 8192x8 RAM. Address = {Y[5:0], X[6:0]}; only the 4800 in-range cells are used.
- RAM contents are not affected by RST.
- Display path:
  - cellX = PIX_COL >> CELL_SHIFT; cellY = PIX_ROW >> CELL_SHIFT.
  - RGB = RAM[{cellY, cellX}] via asynchronous read, zero clock latency.
  - If PIX_COL >= H_CELLS<<CELL_SHIFT or PIX_ROW >= V_CELLS<<CELL_SHIFT, RGB = 0.
  - The display path is never stalled. It keeps reading during MCU writes and during a clear, so a clear in progress is visible.
- Reset values:
  - MCU_RD = 0, MCU_RD_VALID = 0, BUSY = 0 (so READY = 1).
  - FSM = IDLE; clear counters = 0.
- MCU write:
  - Accepted on the edge where MCU_WE=1 and READY=1.
  - RAM updated at that edge; visible on the display path from the following cycle.
  - Out-of-range X or Y: request accepted, no RAM write.
- MCU read:
  - Accepted on the edge where MCU_RE=1 and READY=1.
  - MCU_RD and MCU_RD_VALID are registered; MCU_RD_VALID=1 for exactly the cycle after acceptance.
  - Out-of-range address returns 0x00.
  - MCU_RD holds its value until the next accepted read.
- Read and write in the same cycle at the same address: read returns the old data (read-before-write); the write completes normally.
- Requests while BUSY=1 are ignored: no RAM change, no MCU_RD_VALID. The MCU must hold a request until READY=1.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR: on an edge with CLR=1. CLR_COLOR is latched, counters cx=0 and cy=0, BUSY becomes 1 on the next cycle. An MCU request accepted on that same edge still executes.
  - CLEAR, each cycle: write the latched colour to {cy, cx}. cx increments; when cx wraps from H_CELLS-1 to 0, cy increments.
  - CLEAR -> IDLE: on the edge that writes cell (79,59). BUSY is 0 on the following cycle.
  - A clear therefore spans exactly H_CELLS*V_CELLS = 4800 cycles with BUSY=1.
  - CLR while in CLEAR is ignored; there is no restart.
- RST mid-clear: the clear aborts and BUSY=0 on the next cycle. Cells already written keep the fill colour; the remaining cells keep their old contents.
- Counter widths: cx is 7 bits, cy is 6 bits. No arithmetic overflow is possible at the default parameters.

Test Plan:
- Write/display: write X=5, Y=2, data 0xE3 with READY=1; then drive PIX_COL=40..47 and PIX_ROW=16..23. Required: RGB = {111,000,11} on all 64 pixels. PIX_COL=48 gives a different cell.
- Read latency/collision:
  - Pulse MCU_RE at X=5, Y=2: MCU_RD=0xE3 with MCU_RD_VALID high exactly one cycle later.
  - RE and WE with 0x1C to the same cell in the same cycle: MCU_RD=0xE3, then a subsequent read returns 0x1C.
- Out-of-range:
  - Write X=80, Y=0 with 0xFF: no cell changes.
  - Read X=0, Y=60: returns 0x00.
  - PIX_COL=700, PIX_ROW=10: RGB=0.
- Clear:
  - Pulse CLR with CLR_COLOR=0x03: BUSY high for exactly 4800 cycles.
  - Afterwards, reads of (0,0), (79,0), (0,59) and (79,59) all return 0x03.
  - MCU_WE issued mid-clear: ignored, READY=0.
- Reset mid-clear:
  - Preload all cells to 0xAA, start a clear to 0x00, assert RST at clear cycle 100.
  - Required: BUSY=0 the next cycle; cells 0..99 read 0x00; cell 100 (X=20, Y=1) reads 0xAA.
- Clear collisions:
  - CLR with a second CLR pulse at cycle 2000: BUSY still falls after 4800 total cycles.
  - CLR and a WE of 0x55 to (3,3) on the same edge: the write executes, then (3,3) ends as the clear colour.
